i2f_pipe: RTL and testbench

//   Three-stage pipelined 32-bit integer -> IEEE-754 binary32 converter, round-to-nearest-even.

---
 rtl/i2f_pkg.sv | 27 ++
 rtl/i2f_pipe_clz.sv | 18 +
 rtl/i2f_pipe.sv | 104 ++++++++++
 tb/tb_i2f_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2f_pkg.sv
// Shared types and constants for the int -> binary32 conversion pipeline.
package i2f_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_TOP  = EXP_BIAS + 31;
  localparam int unsigned FRAC_W   = 23;

  typedef struct packed {
    logic        v;
    logic        sign;
    logic [31:0] mag;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic        sign;
    logic        zflag;
    logic [7:0]  exp;
    logic [31:0] norm;
  } s2_t;

  // Biased exponent of a magnitude whose leading one sits at bit (31 - lz).
  function automatic logic [7:0] norm_exp(input logic [4:0] lz);
    return 8'(EXP_TOP) - {3'b000, lz};
  endfunction

endpackage

// File: rtl/i2f_pipe_clz.sv
// 32-bit leading-zero counter; o_lz is don't-care when o_zero is set.
module i2f_pipe_clz (
  input  logic [31:0] i_data,
  output logic [4:0]  o_lz,
  output logic        o_zero
);

  // Ascending scan: the highest set bit writes last and wins.
  always_comb begin
    o_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_lz = 5'(31 - i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/i2f_pipe.sv
// Three-stage integer -> binary32 converter (round-to-nearest-even) with
// a single global advance enable shared by every stage.
module i2f_pipe
  import i2f_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  logic        w_en;
  s1_t         w_s1_d, r_s1;
  s2_t         w_s2_d, r_s2;
  logic [4:0]  w_lz;
  logic        w_zero;
  logic [FRAC_W-1:0] w_frac;
  logic        w_guard, w_sticky, w_round_up;
  logic [23:0] w_sum;
  logic [7:0]  w_exp;
  logic [31:0] w_result;
  logic        w_inexact;
  logic        w_unused;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic        r_out_inexact;

  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;

  // S1: sign/magnitude split; -0x80000000 wraps back to 0x80000000, which is the right magnitude.
  always_comb begin
    w_s1_d.v    = in_valid;
    w_s1_d.sign = SIGNED & in_data[31];
    w_s1_d.mag  = w_s1_d.sign ? (~in_data + 32'd1) : in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (w_en) begin
      r_s1 <= w_s1_d;
    end
  end

  // S2: normalise so the leading one lands on bit 31.
  i2f_pipe_clz u_clz (
    .i_data (r_s1.mag),
    .o_lz   (w_lz),
    .o_zero (w_zero)
  );

  always_comb begin
    w_s2_d.v     = r_s1.v;
    w_s2_d.sign  = r_s1.sign;
    w_s2_d.zflag = w_zero;
    w_s2_d.exp   = norm_exp(w_lz);
    w_s2_d.norm  = r_s1.mag << w_lz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else if (w_en) begin
      r_s2 <= w_s2_d;
    end
  end

  // S3: round to nearest even and pack; bit 31 of norm is the implicit one.
  assign w_unused   = r_s2.norm[31];
  assign w_frac     = r_s2.norm[30 -: FRAC_W];
  assign w_guard    = r_s2.norm[7];
  assign w_sticky   = |r_s2.norm[6:0];
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
  assign w_sum      = {1'b0, w_frac} + 24'(w_round_up);
  // On mantissa carry w_sum[22:0] is already zero; only the exponent bumps.
  assign w_exp      = r_s2.exp + 8'(w_sum[23]);
  assign w_result   = r_s2.zflag ? 32'h0 : {r_s2.sign, w_exp, w_sum[FRAC_W-1:0]};
  assign w_inexact  = ~r_s2.zflag & (w_guard | w_sticky);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= 32'h0;
      r_out_inexact <= 1'b0;
    end else if (w_en) begin
      r_out_valid   <= r_s2.v;
      r_out_data    <= w_result;
      r_out_inexact <= w_inexact;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_i2f_pipe.sv
// Bench for i2f_pipe: a signed and an unsigned instance share stimulus; each is
// scoreboarded against a real-arithmetic reference every cycle.
module tb_i2f_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_ready_s    [2];
  logic        out_valid_s   [2];
  logic        out_inexact_s [2];
  logic [31:0] out_data_s    [2];

  always #5 clk = ~clk;

  i2f_pipe #(.SIGNED(1'b1)) u_dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s[0]),
    .in_data     (in_data),
    .out_valid   (out_valid_s[0]),
    .out_ready   (out_ready),
    .out_data    (out_data_s[0]),
    .out_inexact (out_inexact_s[0])
  );

  i2f_pipe #(.SIGNED(1'b0)) u_dut_u (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s[1]),
    .in_data     (in_data),
    .out_valid   (out_valid_s[1]),
    .out_ready   (out_ready),
    .out_data    (out_data_s[1]),
    .out_inexact (out_inexact_s[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        inx;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          stall_cnt [2] = '{0, 0};
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [31:0] prev_data  [2];
  logic        prev_inx   [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: the integer is exact in a double; round its 52-bit fraction to 23 bits (RNE).
  function automatic logic [32:0] ref_cvt(input logic [31:0] x, input bit sgn);
    longint      v;
    real         r;
    logic [63:0] b;
    logic [30:0] mag;
    logic [28:0] rem;
    int          e;
    if (x == 32'h0) return 33'h0;
    v   = sgn ? longint'($signed(x)) : longint'({32'h0, x});
    r   = real'(v);
    b   = $realtobits(r);
    e   = int'(b[62:52]) - 1023 + 127;
    mag = {8'(e), b[51:29]};
    rem = b[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
    return {rem != 29'h0, b[63], mag};
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic check_cycle(input int d);
    exp_t e;
    logic ov;
    int   lat_req;
    ov = out_valid_s[d];
    chk($sformatf("dut%0d in_ready", d), 64'(in_ready_s[d]), 64'(!ov || out_ready));
    if (prev_stall[d]) begin
      chk($sformatf("dut%0d hold_data", d), 64'(out_data_s[d]), 64'(prev_data[d]));
      chk($sformatf("dut%0d hold_inexact", d), 64'(out_inexact_s[d]), 64'(prev_inx[d]));
    end
    if (ov) begin
      if (sb_size(d) == 0) begin
        chk($sformatf("dut%0d spurious_out_valid", d), 64'(ov), 64'(0));
      end else if (out_ready) begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        lat_req = 3 + stall_cnt[d] - e.stl;
        chk($sformatf("dut%0d out_data", d), 64'(out_data_s[d]), 64'(e.data));
        chk($sformatf("dut%0d out_inexact", d), 64'(out_inexact_s[d]), 64'(e.inx));
        chk($sformatf("dut%0d latency", d), 64'(cyc - e.cyc), 64'(lat_req));
      end
    end
    if (in_valid && in_ready_s[d]) begin
      logic [32:0] r;
      r      = ref_cvt(in_data, d == 0);
      e.data = r[31:0];
      e.inx  = r[32];
      e.cyc  = cyc;
      e.stl  = stall_cnt[d];
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    if (ov && !out_ready) stall_cnt[d]++;
    prev_stall[d] = ov && !out_ready;
    prev_data[d]  = out_data_s[d];
    prev_inx[d]   = out_inexact_s[d];
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      check_cycle(0);
      check_cycle(1);
    end
    cyc++;
  end

  // rs/ru are {inexact, data} for the signed and unsigned instance.
  task automatic directed(input logic [31:0] x, input logic [32:0] rs, input logic [32:0] ru);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk($sformatf("dir %h early_valid", x), 64'({out_valid_s[0], out_valid_s[1]}), 64'(0));
    @(posedge clk); @(negedge clk);
    chk($sformatf("dir %h valid", x), 64'({out_valid_s[0], out_valid_s[1]}), 64'(2'b11));
    chk($sformatf("dir %h signed", x), 64'({out_inexact_s[0], out_data_s[0]}), 64'(rs));
    chk($sformatf("dir %h unsigned", x), 64'({out_inexact_s[1], out_data_s[1]}), 64'(ru));
  endtask

  task automatic run_bp();
    logic [31:0] vec [8];
    int sent = 0;
    int t    = 0;
    vec[0] = 32'd1;        vec[1] = 32'd2;          vec[2] = 32'd3;        vec[3] = 32'hFFFF_FFFB;
    vec[4] = 32'd100;      vec[5] = 32'h00FF_FFFF;  vec[6] = 32'h1234_5678; vec[7] = 32'd0;
    while (sent < 8 && t < 200) begin
      @(posedge clk); #1;
      out_ready = !(t >= 3 && t < 8);
      in_valid  = 1'b1;
      in_data   = vec[sent];
      @(negedge clk);
      if (in_ready_s[0]) sent++;
      t++;
    end
    chk("bp_sent", 64'(sent), 64'(8));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_left_s", 64'(sb0.size()), 64'(0));
    chk("bp_left_u", 64'(sb1.size()), 64'(0));
  endtask

  task automatic run_reset();
    logic [31:0] vec [3];
    vec[0] = 32'd7; vec[1] = 32'd9; vec[2] = 32'd11;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = vec[i];
    end
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_async_valid", 64'({out_valid_s[0], out_valid_s[1]}), 64'(0));
    chk("rst_async_data", 64'({out_data_s[0], out_data_s[1]}), 64'(0));
    chk("rst_async_inexact", 64'({out_inexact_s[0], out_inexact_s[1]}), 64'(0));
    sb0.delete();
    sb1.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    directed(32'd5, {1'b0, 32'h40A0_0000}, {1'b0, 32'h40A0_0000});
  endtask

  function automatic logic [31:0] gen_data();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom >> $urandom_range(0, 31);
      2:       return sp[$urandom_range(0, 4)];
      default: return ($urandom_range(0, 1) ? 32'h0100_0000 : 32'hFF00_0000) | $urandom_range(0, 3);
    endcase
  endfunction

  task automatic run_random(input int n);
    int   sent    = 0;
    int   t       = 0;
    logic pending = 1'b0;
    while (sent < n && t < 60000) begin
      @(posedge clk); #1;
      if (!pending && $urandom_range(0, 99) < 70) begin
        pending = 1'b1;
        in_data = gen_data();
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (pending && in_ready_s[0]) begin
        pending = 1'b0;
        sent++;
      end
      t++;
    end
    chk("rand_sent", 64'(sent), 64'(n));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rand_left_s", 64'(sb0.size()), 64'(0));
    chk("rand_left_u", 64'(sb1.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    #2;
    chk("reset_valid", 64'({out_valid_s[0], out_valid_s[1]}), 64'(0));
    chk("reset_data", 64'({out_data_s[0], out_data_s[1]}), 64'(0));
    chk("reset_inexact", 64'({out_inexact_s[0], out_inexact_s[1]}), 64'(0));

    chk("model 1", 64'(ref_cvt(32'h1, 1'b1)), 64'({1'b0, 32'h3F80_0000}));
    chk("model -1", 64'(ref_cvt(32'hFFFF_FFFF, 1'b1)), 64'({1'b0, 32'hBF80_0000}));
    chk("model umax", 64'(ref_cvt(32'hFFFF_FFFF, 1'b0)), 64'({1'b1, 32'h4F80_0000}));
    chk("model tie_up", 64'(ref_cvt(32'h0100_0003, 1'b1)), 64'({1'b1, 32'h4B80_0002}));
    chk("model smin", 64'(ref_cvt(32'h8000_0000, 1'b1)), 64'({1'b0, 32'hCF00_0000}));

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'({in_ready_s[0], in_ready_s[1]}), 64'(2'b11));

    directed(32'h0000_0001, {1'b0, 32'h3F80_0000}, {1'b0, 32'h3F80_0000});
    directed(32'hFFFF_FFFF, {1'b0, 32'hBF80_0000}, {1'b1, 32'h4F80_0000});
    directed(32'h0000_0000, {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0000});
    directed(32'h8000_0000, {1'b0, 32'hCF00_0000}, {1'b0, 32'h4F00_0000});
    directed(32'h0100_0001, {1'b1, 32'h4B80_0000}, {1'b1, 32'h4B80_0000});
    directed(32'h0100_0003, {1'b1, 32'h4B80_0002}, {1'b1, 32'h4B80_0002});
    directed(32'h7FFF_FFFF, {1'b1, 32'h4F00_0000}, {1'b1, 32'h4F00_0000});

    run_bp();
    run_reset();
    run_random(10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
